// File: rtl/param_mealy_seq_detector_pkg.sv
// rtl/param_mealy_seq_detector_pkg.sv - shared types and default constants for the sequence detector
package param_mealy_seq_detector_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } det_state_e;

  localparam int          DEF_PAT_LEN   = 4;
  localparam logic [31:0] DEF_PAT_RESET = 32'b1011;
  localparam int          DEF_CNT_W     = 8;

endpackage

// File: rtl/param_mealy_seq_detector_sat_counter.sv
// rtl/param_mealy_seq_detector_sat_counter.sv - saturating up-counter, clear has priority over increment
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != {W{1'b1}})) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/param_mealy_seq_detector.sv
// rtl/param_mealy_seq_detector.sv - Mealy detector for a loadable PAT_LEN-bit pattern on a serial stream
module param_mealy_seq_detector
  import param_mealy_seq_detector_pkg::*;
#(
  parameter int                 PAT_LEN   = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PAT_RESET = DEF_PAT_RESET[PAT_LEN-1:0],
  parameter int                 CNT_W     = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               x,
  input  logic               overlap,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               count_clr,
  output logic               z,
  output logic               z_reg,
  output logic               armed,
  output logic [CNT_W-1:0]   match_count
);

  localparam int             FW       = $clog2(PAT_LEN);
  localparam logic [FW-1:0]  FILL_MAX = FW'(PAT_LEN - 1);

  det_state_e         state_q, state_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic [PAT_LEN-2:0] hist_q, hist_d;
  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic [PAT_LEN-2:0] hist_shift;
  logic               z_reg_q;

  // A 1-bit history has no older bits to keep, so the shift degenerates to a load.
  if (PAT_LEN == 2) begin : g_hist_2
    assign hist_shift = x;
  end else begin : g_hist_n
    assign hist_shift = {hist_q[PAT_LEN-3:0], x};
  end

  assign armed = (state_q == ARMED);
  assign z     = en & armed & ~pat_load & (hist_q == pat_q[PAT_LEN-1:1]) & (x == pat_q[0]);

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    hist_d  = hist_q;
    pat_d   = pat_q;
    if (pat_load) begin
      pat_d   = pat_in;
      hist_d  = '0;
      fill_d  = '0;
      state_d = FILL;
    end else if (en) begin
      hist_d = hist_shift;
      case (state_q)
        FILL: begin
          fill_d = fill_q + FW'(1);
          if (fill_d == FILL_MAX) begin
            state_d = ARMED;
          end
        end
        ARMED: begin
          // Non-overlapping mode consumes the matched bits and starts refilling.
          if (z && !overlap) begin
            fill_d  = '0;
            state_d = FILL;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
      fill_q  <= '0;
      hist_q  <= '0;
      pat_q   <= PAT_RESET;
      z_reg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      hist_q  <= hist_d;
      pat_q   <= pat_d;
      z_reg_q <= z;
    end
  end

  assign z_reg = z_reg_q;

  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (z),
    .clr  (count_clr),
    .q    (match_count)
  );

endmodule

// File: tb/tb_param_mealy_seq_detector.sv
// tb/tb_param_mealy_seq_detector.sv - vector table, corner sequences and random stream against a queue model
module tb_param_mealy_seq_detector;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, x, overlap, pat_load, count_clr;
  logic [3:0] pat_in;
  logic       zo[2], zro[2], armo[2];
  logic [7:0] cnt0;
  logic [1:0] cnt1;
  bit         clk_run = 1'b1;

  int total = 0;
  int bad   = 0;

  // Model: the valid bits received since the last reset/load/consuming match.
  bit         mb[$];
  logic [3:0] mp;
  int         mc[2];
  int         mmax[2] = '{255, 3};
  bit         mzr;

  typedef struct {
    bit rst; bit e; bit xx; bit ov;
    int ez; int ea; int ec; int ezr;
  } vec_t;
  vec_t tbl[$];

  always #5 if (clk_run) clk = ~clk;

  param_mealy_seq_detector #(.PAT_LEN(4), .PAT_RESET(4'b1011), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .en(en), .x(x), .overlap(overlap), .pat_load(pat_load),
    .pat_in(pat_in), .count_clr(count_clr), .z(zo[0]), .z_reg(zro[0]), .armed(armo[0]),
    .match_count(cnt0));

  param_mealy_seq_detector #(.PAT_LEN(4), .PAT_RESET(4'b1011), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .x(x), .overlap(overlap), .pat_load(pat_load),
    .pat_in(pat_in), .count_clr(count_clr), .z(zo[1]), .z_reg(zro[1]), .armed(armo[1]),
    .match_count(cnt1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic bit m_z();
    logic [3:0] v;
    if (!en || pat_load || mb.size() < 3) return 1'b0;
    v = {mb[0], mb[1], mb[2], x};
    return v == mp;
  endfunction

  function automatic void model_reset();
    mb.delete();
    mp    = 4'b1011;
    mc[0] = 0;
    mc[1] = 0;
    mzr   = 1'b0;
  endfunction

  function automatic void model_step(input bit mz);
    if (pat_load) begin
      mb.delete();
      mp = pat_in;
    end else if (en) begin
      if (mz && !overlap) begin
        mb.delete();
      end else begin
        mb.push_back(x);
        if (mb.size() > 3) void'(mb.pop_front());
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (count_clr) mc[k] = 0;
      else if (mz && mc[k] < mmax[k]) mc[k] = mc[k] + 1;
    end
    mzr = mz;
  endfunction

  task automatic apply(input bit e, input bit xx, input bit ov, input bit ld, input logic [3:0] pin,
                       input bit clr, input int ez, input int ea, input int ec, input int ezr,
                       input string tag);
    bit mz;
    en = e; x = xx; overlap = ov; pat_load = ld; pat_in = pin; count_clr = clr;
    #2;
    mz = m_z();
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_model_z"}, zo[k], mz);
      chk({tag, "_model_armed"}, armo[k], mb.size() >= 3);
      chk({tag, "_model_zreg"}, zro[k], mzr);
      chk({tag, "_model_cnt"}, (k == 0) ? 32'(cnt0) : 32'(cnt1), mc[k]);
    end
    if (ez >= 0)  chk({tag, "_z"}, zo[0], ez);
    if (ea >= 0)  chk({tag, "_armed"}, armo[0], ea);
    if (ec >= 0)  chk({tag, "_cnt"}, cnt0, ec);
    if (ezr >= 0) chk({tag, "_zreg"}, zro[0], ezr);
    @(posedge clk);
    #1;
    model_step(mz);
  endtask

  task automatic do_reset();
    en = 0; x = 0; overlap = 0; pat_load = 0; pat_in = 0; count_clr = 0;
    reset = 0;
    model_reset();
    #3;
    reset = 1;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t V(input bit r, input bit e, input bit xx, input bit ov,
                             input int ez, input int ea, input int ec, input int ezr);
    vec_t v;
    v.rst = r; v.e = e; v.xx = xx; v.ov = ov; v.ez = ez; v.ea = ea; v.ec = ec; v.ezr = ezr;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    en = 0; x = 0; overlap = 0; pat_load = 0; pat_in = 0; count_clr = 0;
    reset = 0;
    model_reset();
    #1;
    chk("rst_z", zo[0], 0);
    chk("rst_armed", armo[0], 0);
    chk("rst_zreg", zro[0], 0);
    chk("rst_cnt", cnt0, 0);
    #2 reset = 1;
    @(posedge clk);
    #1;

    // overlap=1: stream 1,0,1,1,0,1,1 then an idle cycle to observe results
    tbl.push_back(V(1,1,1,1, 0,0,0,0)); tbl.push_back(V(0,1,0,1, 0,0,0,0));
    tbl.push_back(V(0,1,1,1, 0,0,0,0)); tbl.push_back(V(0,1,1,1, 1,1,0,0));
    tbl.push_back(V(0,1,0,1, 0,1,1,1)); tbl.push_back(V(0,1,1,1, 0,1,1,0));
    tbl.push_back(V(0,1,1,1, 1,1,1,0)); tbl.push_back(V(0,0,0,1, 0,1,2,1));
    // overlap=0: same stream, then 1,0,1,1
    tbl.push_back(V(1,1,1,0, 0,0,0,0)); tbl.push_back(V(0,1,0,0, 0,0,0,0));
    tbl.push_back(V(0,1,1,0, 0,0,0,0)); tbl.push_back(V(0,1,1,0, 1,1,0,0));
    tbl.push_back(V(0,1,0,0, 0,0,1,1)); tbl.push_back(V(0,1,1,0, 0,0,1,0));
    tbl.push_back(V(0,1,1,0, 0,0,1,0)); tbl.push_back(V(0,1,1,0, 0,1,1,0));
    tbl.push_back(V(0,1,0,0, 0,1,1,0)); tbl.push_back(V(0,1,1,0, 0,1,1,0));
    tbl.push_back(V(0,1,1,0, 1,1,1,0)); tbl.push_back(V(0,0,0,0, 0,0,2,1));
    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      apply(tbl[i].e, tbl[i].xx, tbl[i].ov, 1'b0, 4'b0, 1'b0,
            tbl[i].ez, tbl[i].ea, tbl[i].ec, tbl[i].ezr, $sformatf("tbl%0d", i));
    end

    // en gaps with x toggling inside a match
    do_reset();
    apply(1,1,1,0,4'b0,0, 0,0,-1,-1,"gap_b1");
    apply(1,0,1,0,4'b0,0, 0,0,-1,-1,"gap_b2");
    apply(0,1,1,0,4'b0,0, 0,0,-1,-1,"gap_off1");
    apply(0,0,1,0,4'b0,0, 0,0,-1,-1,"gap_off2");
    apply(0,1,1,0,4'b0,0, 0,0,-1,-1,"gap_off3");
    apply(1,1,1,0,4'b0,0, 0,0,-1,-1,"gap_b3");
    apply(1,1,1,0,4'b0,0, 1,1,0,-1,"gap_b4");

    // pattern load mid-stream with a simultaneous count clear
    apply(1,1,1,0,4'b0,0, 0,-1,1,-1,"ld_old1");
    apply(1,0,1,0,4'b0,0, 0,-1,1,-1,"ld_old2");
    apply(1,1,1,1,4'b0110,1, 0,-1,1,-1,"ld_load");
    apply(1,0,1,0,4'b0,0, 0,0,0,-1,"ld_n1");
    apply(1,1,1,0,4'b0,0, 0,0,0,-1,"ld_n2");
    apply(1,1,1,0,4'b0,0, 0,0,0,-1,"ld_n3");
    apply(1,0,1,0,4'b0,0, 1,1,0,-1,"ld_n4");
    apply(0,0,1,0,4'b0,0, 0,1,1,1,"ld_idle");

    // saturation on the 2-bit counter, then clear colliding with a match
    apply(1,1,1,1,4'b1111,1, 0,-1,1,-1,"sat_load");
    for (int i = 0; i < 8; i++) begin
      apply(1,1,1,0,4'b0,0, (i >= 3) ? 1 : 0, (i >= 3) ? 1 : 0, (i < 4) ? 0 : i - 3, -1,
            $sformatf("sat_b%0d", i + 1));
    end
    chk("sat_cnt2", cnt1, 3);
    chk("sat_cnt8", cnt0, 5);
    apply(1,1,1,0,4'b0,1, 1,1,5,1,"sat_clr");
    apply(0,0,1,0,4'b0,0, 0,1,0,1,"sat_after");
    chk("sat_clr_cnt2", cnt1, 0);

    // asynchronous reset with the clock stopped, partway into a match
    apply(1,1,1,1,4'b1011,0, 0,-1,0,-1,"ar_load");
    apply(1,1,1,0,4'b0,0, 0,0,-1,-1,"ar_a1");
    apply(1,0,1,0,4'b0,0, 0,0,-1,-1,"ar_a2");
    apply(1,1,1,0,4'b0,0, 0,0,-1,-1,"ar_a3");
    apply(1,1,1,0,4'b0,0, 1,1,0,-1,"ar_a4");
    apply(1,1,1,0,4'b0,0, 0,1,1,1,"ar_b1");
    apply(1,0,1,0,4'b0,0, 0,1,1,0,"ar_b2");
    apply(1,1,1,0,4'b0,0, 0,1,1,0,"ar_b3");
    en = 1; x = 1; overlap = 1; pat_load = 0; count_clr = 0;
    #2;
    chk("ar_pre_z", zo[0], 1);
    chk("ar_pre_cnt", cnt0, 1);
    clk_run = 0;
    reset = 0;
    #1;
    chk("ar_z", zo[0], 0);
    chk("ar_armed", armo[0], 0);
    chk("ar_zreg", zro[0], 0);
    chk("ar_cnt", cnt0, 0);
    chk("ar_cnt2", cnt1, 0);
    en = 0; x = 0;
    model_reset();
    #20;
    reset = 1;
    #3;
    clk_run = 1;
    @(posedge clk);
    #1;
    apply(1,0,1,1,4'b0110,0, 0,-1,-1,-1,"ar_ld0110");
    do_reset();
    apply(1,1,1,0,4'b0,0, 0,0,0,-1,"ar_r1");
    apply(1,0,1,0,4'b0,0, 0,0,0,-1,"ar_r2");
    apply(1,1,1,0,4'b0,0, 0,0,0,-1,"ar_r3");
    apply(1,1,1,0,4'b0,0, 1,1,0,-1,"ar_r4");

    // random stream against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      apply($urandom_range(0, 4) != 0, 1'($urandom), 1'($urandom),
            $urandom_range(0, 29) == 0, 4'($urandom), $urandom_range(0, 39) == 0,
            -1, -1, -1, -1, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
